// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
//   Two-entry valid/ready skid buffer between the ALU and register-file
//   writeback. It captures the ALU's packed {overflow, equals, above, result}
//   output and its destination index. The ALU's combinational output
//   therefore never has to be held stable across a writeback stall.
//   The head entry drives out_*. Commits update the sticky status flags and
//   the retired-operation counter.
//
//   Optional feature macro: OVF_TRAP_EN
//     defined   : an overflowed head entry does not write the register file;
//                 its commit raises a one-cycle ovf_trap pulse.
//     undefined : overflow does not gate out_we; ovf_trap is tied 0.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ready depends on state only
//   in_result, in_rd    packed ALU output [DATA_W+2:0], destination index
//   out_valid/out_ready writeback handshake on the head entry
//   out_data/out_rd     head entry payload
//   out_we              register-file write enable (never for rd 0)
//   out_flags           head {overflow, equals, above}
//   status_flags        sticky OR of committed flags
//   status_clr          clears the sticky flags
//   retired_count       number of commits, wraps silently
//   ovf_trap            pulse the cycle after an overflowed commit
module alu_writeback_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W+2:0]     in_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_we,
  output logic [2:0]            out_flags,
  output logic [2:0]            status_flags,
  input  logic                  status_clr,
  output logic [CNT_W-1:0]      retired_count,
  output logic                  ovf_trap
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t                r_state;
  logic [DATA_W-1:0]     r_h_data, r_s_data;
  logic [REG_ADDR_W-1:0] r_h_rd,   r_s_rd;
  logic [2:0]            r_h_flags, r_s_flags;
  logic [2:0]            r_status;
  logic [CNT_W-1:0]      r_cnt;

  logic w_accept, w_commit;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_commit  = out_valid & out_ready;

  // Head registers are cleared when the buffer drains, so out_* read 0 while EMPTY.
  assign out_data      = r_h_data;
  assign out_rd        = r_h_rd;
  assign out_flags     = r_h_flags;
  assign status_flags  = r_status;
  assign retired_count = r_cnt;

`ifdef OVF_TRAP_EN
  logic r_ovf_trap;
  assign out_we   = out_valid & (r_h_rd != '0) & ~r_h_flags[2];
  assign ovf_trap = r_ovf_trap;

  always_ff @(posedge clk) begin
    if (!rst_n) r_ovf_trap <= 1'b0;
    else        r_ovf_trap <= w_commit & r_h_flags[2];
  end
`else
  assign out_we   = out_valid & (r_h_rd != '0);
  assign ovf_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_h_data  <= '0;
      r_h_rd    <= '0;
      r_h_flags <= '0;
      r_s_data  <= '0;
      r_s_rd    <= '0;
      r_s_flags <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) begin
          r_h_data  <= in_result[DATA_W-1:0];
          r_h_flags <= in_result[DATA_W+2:DATA_W];
          r_h_rd    <= in_rd;
          r_state   <= ONE;
        end
        ONE: begin
          if (w_accept && w_commit) begin
            // The new entry replaces the departing head directly.
            r_h_data  <= in_result[DATA_W-1:0];
            r_h_flags <= in_result[DATA_W+2:DATA_W];
            r_h_rd    <= in_rd;
          end else if (w_accept) begin
            r_s_data  <= in_result[DATA_W-1:0];
            r_s_flags <= in_result[DATA_W+2:DATA_W];
            r_s_rd    <= in_rd;
            r_state   <= FULL;
          end else if (w_commit) begin
            r_h_data  <= '0;
            r_h_flags <= '0;
            r_h_rd    <= '0;
            r_state   <= EMPTY;
          end
        end
        FULL: if (w_commit) begin
          r_h_data  <= r_s_data;
          r_h_flags <= r_s_flags;
          r_h_rd    <= r_s_rd;
          r_s_data  <= '0;
          r_s_flags <= '0;
          r_s_rd    <= '0;
          r_state   <= ONE;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // A commit and a clear in the same cycle leave only the committed flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_status <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_commit) begin
        r_status <= status_clr ? r_h_flags : (r_status | r_h_flags);
        r_cnt    <= r_cnt + 1'b1;
      end else if (status_clr) begin
        r_status <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
module tb_alu_writeback_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [34:0] in_result;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [2:0]  out_flags;
  logic [2:0]  status_flags;
  logic        status_clr;
  logic [15:0] retired_count;
  logic        ovf_trap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_writeback_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
    .out_flags(out_flags), .status_flags(status_flags),
    .status_clr(status_clr), .retired_count(retired_count),
    .ovf_trap(ovf_trap)
  );

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_rd = '0;
    out_ready = 1'b0; status_clr = 1'b0;
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_we", out_we, 0);
    check("rst_status", status_flags, 0);
    check("rst_count", retired_count, 0);
    check("rst_trap", ovf_trap, 0);
    rst_n = 1'b1;

    // single push, immediate commit
    in_valid = 1'b1; in_result = {3'b000, 32'd7}; in_rd = 5'd5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 7);
    check("t1_rd", out_rd, 5);
    check("t1_we", out_we, 1);
    check("t1_cnt_before", retired_count, 0);
    step();
    check("t1_empty", out_valid, 0);
    check("t1_cnt", retired_count, 1);
    check("t1_empty_data", out_data, 0);

    // fill to FULL under stall, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = {3'b000, 32'd10}; in_rd = 5'd1;
    step();
    in_result = {3'b000, 32'd20}; in_rd = 5'd2;
    step();
    in_valid = 1'b0;
    check("t2_full_ready", in_ready, 0);
    check("t2_head", out_data, 10);
    step();
    check("t2_held", out_data, 10);
    check("t2_held_rd", out_rd, 1);
    out_ready = 1'b1;
    step();
    check("t2_ready_after", in_ready, 1);
    check("t2_second", out_data, 20);
    check("t2_second_rd", out_rd, 2);
    check("t2_cnt1", retired_count, 2);
    step();
    check("t2_drained", out_valid, 0);
    check("t2_cnt2", retired_count, 3);
    out_ready = 1'b0;

    // ONE: push and commit in the same cycle
    in_valid = 1'b1; in_result = {3'b000, 32'd1}; in_rd = 5'd1;
    step();
    in_result = {3'b000, 32'd2}; in_rd = 5'd2; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t3_head", out_data, 2);
    check("t3_valid", out_valid, 1);
    check("t3_ready", in_ready, 1);
    check("t3_cnt", retired_count, 4);
    step();
    check("t3_empty", out_valid, 0);
    check("t3_cnt2", retired_count, 5);
    out_ready = 1'b0;

    // overflowed entry
    in_valid = 1'b1; in_result = {3'b100, 32'h33}; in_rd = 5'd3;
    step();
    in_valid = 1'b0;
    check("t4_flags", out_flags, 3'b100);
`ifdef OVF_TRAP_EN
    check("t4_we_gated", out_we, 0);
`else
    check("t4_we", out_we, 1);
`endif
    check("t4_status_pre", status_flags, 0);
    out_ready = 1'b1;
    step();
    check("t4_status", status_flags, 3'b100);
    check("t4_cnt", retired_count, 6);
`ifdef OVF_TRAP_EN
    check("t4_trap", ovf_trap, 1);
`else
    check("t4_trap_off", ovf_trap, 0);
`endif
    step();
    check("t4_trap_end", ovf_trap, 0);
    check("t4_sticky", status_flags, 3'b100);

    // clear together with a commit: committed flags win
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = {3'b010, 32'h44}; in_rd = 5'd4;
    step();
    in_valid = 1'b0; out_ready = 1'b1; status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("t4_clr_commit", status_flags, 3'b010);
    check("t4_cnt2", retired_count, 7);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("t4_clr_only", status_flags, 0);

    // rd 0 never written
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = {3'b000, 32'h55}; in_rd = 5'd0;
    step();
    in_valid = 1'b0;
    check("t5_rd0_valid", out_valid, 1);
    check("t5_rd0_we", out_we, 0);
    out_ready = 1'b1;
    step();
    check("t5_cnt", retired_count, 8);

    // counter wrap: one accept edge, then one commit per edge
    in_valid = 1'b1; in_result = {3'b000, 32'h66}; in_rd = 5'd1;
    step();
    repeat (65527) step();
    check("t5_cnt_max", retired_count, 16'hFFFF);
    step();
    check("t5_cnt_wrap", retired_count, 0);
    in_valid = 1'b0;
    step();
    check("t5_cnt_after", retired_count, 1);
    check("t5_empty", out_valid, 0);

    // reset while FULL and stalled
    in_valid = 1'b1; in_result = {3'b001, 32'h77}; in_rd = 5'd7;
    step();
    in_valid = 1'b0;
    step();
    check("t6_status_set", status_flags, 3'b001);
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = {3'b000, 32'hAA}; in_rd = 5'd1;
    step();
    in_result = {3'b000, 32'hBB}; in_rd = 5'd2;
    step();
    in_valid = 1'b0;
    check("t6_full", in_ready, 0);
    rst_n = 1'b0;
    step();
    check("t6_valid", out_valid, 0);
    check("t6_ready", in_ready, 1);
    check("t6_status", status_flags, 0);
    check("t6_cnt", retired_count, 0);
    check("t6_data", out_data, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    check("t6_no_ghost", out_valid, 0);
    check("t6_cnt_hold", retired_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
Downstream neighbour of the ALU: captures the ALU's 35-bit packed output ({overflow, equals, above, result[31:0]}) with its destination register index. It is a 2-entry valid/ready skid buffer between execute and register-file writeback. On commit it exposes result and write enable, keeps sticky status flags and counts retired operations, so the ALU's combinational output never has to be held stable across a stall.

Parameters:
DATA_W, 32, result data width; packed input width is DATA_W+3
REG_ADDR_W, 5, destination register index width
CNT_W, 16, retired-operation counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  upstream presents a valid ALU result
in_ready  output  1  stage can accept this cycle
in_result  input  DATA_W+3  [31:0] data, [32] above, [33] equals, [34] overflow
in_rd  input  REG_ADDR_W  destination register index
out_valid  output  1  head entry valid
out_ready  input  1  writeback consumes head entry
out_data  output  DATA_W  head result data
out_rd  output  REG_ADDR_W  head destination index
out_we  output  1  register-file write enable for head entry
out_flags  output  3  head flags {overflow, equals, above}
status_flags  output  3  sticky {overflow, equals, above}
status_clr  input  1  clear sticky flags
retired_count  output  CNT_W  number of committed entries
ovf_trap  output  1  one-cycle pulse on committing an overflowed entry

Behaviour:
- accept = in_valid & in_ready; commit = out_valid & out_ready.
- FSM states: EMPTY (0 entries), ONE, FULL (2). in_ready = (state != FULL), driven from registered state only; never combinationally dependent on out_ready.
- EMPTY: accept -> ONE.
- ONE: accept only -> FULL. Commit only -> EMPTY. Accept and commit together -> stays ONE; the new entry becomes head.
- FULL: commit -> ONE; second entry becomes head. No accept is possible.
- out_valid = (state != EMPTY). out_* come from the head entry register.
- Latency: an entry accepted at edge N is visible on out_* after edge N when the buffer was empty. Order is strictly FIFO.
- Head out_* and flags are held stable while out_valid & !out_ready.
- out_we = out_valid & (out_rd != 0); register 0 is never written.
- Sticky flags: on commit, status_flags |= out_flags. status_clr zeroes them. On clr and commit in the same cycle, the committed flags win (status_flags = out_flags).
- retired_count increments by 1 per commit and wraps 2^CNT_W-1 -> 0 silently.
- ovf_trap = 1 for exactly the cycle after a commit whose out_flags[2]=1; otherwise 0.
- Reset (rst_n=0 at an edge, including mid-stall): state=EMPTY, in_ready=1 after the edge, out_valid=0, out_data=0, out_rd=0, out_we=0, out_flags=0, status_flags=0, retired_count=0, ovf_trap=0; buffered entries are discarded.
- out_* are don't-care in value but driven 0 when EMPTY.

Optional Feature:
OVF_TRAP_EN. Defined: a head entry with overflow=1 has out_we forced to 0, so the destination is not written. The entry still commits, counts and pulses ovf_trap. Undefined: overflow does not gate out_we, ovf_trap is tied 0, and the sticky overflow flag still operates.

Test Plan:
- Reset then single push in_result={3'b000,32'd7}, in_rd=5, out_ready=1 -> out_valid=1 next cycle, out_data=7, out_we=1; then EMPTY; retired_count=1.
- out_ready=0, push A=10, B=20 -> after 2 edges in_ready=0 (FULL), out_data=10 held; raise out_ready -> 10 then 20 commit in order, in_ready=1 after first commit.
- State ONE, push and commit in the same cycle with A=1 head, B=2 incoming -> stays ONE, out_data=2 next cycle, retired_count +1.
- Commit entry with flags 3'b100, rd=3 -> status_flags=3'b100, ovf_trap pulse of 1 cycle. With OVF_TRAP_EN, out_we=0; without it, out_we=1 and ovf_trap=0. status_clr on the same cycle as a commit with flags 3'b010 -> status_flags=3'b010.
- rd=0 entry -> out_we=0. Preset retired_count to 16'hFFFF via 65535 commits, one more commit -> 0.
- rst_n=0 while FULL and stalled -> next cycle out_valid=0, in_ready=1, status_flags=0, retired_count=0; earlier entries never appear.
